// File: rtl/tpu_dma_engine.sv
// tpu_dma_engine: single-channel memory-to-memory copy engine.
//
// A command (src, dst, size in bytes) is accepted in IDLE. The engine then
// alternates between a READ phase, which fills a small staging FIFO from
// memory, and a WRITE phase, which drains the FIFO back to memory at the
// destination. This repeats until every byte is copied, and a one-cycle
// done pulse follows. Commands that are empty or not word aligned go to ERR
// and set the sticky error flag. No memory is accessed for such a command.
//
// Handshake semantics:
//   cmd:  a command transfers on a rising edge where cmd_valid && cmd_ready.
//   mem:  mem_read/mem_write is a request held with a stable mem_addr and
//         mem_wdata until a cycle with mem_ready=1. That cycle completes the
//         access, and read data is taken from mem_rdata in the same cycle.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_src/cmd_dst/cmd_size        byte addresses and byte length
//   abort                           cancel an active READ/WRITE phase
//   mem_addr/mem_read/mem_write     memory request
//   mem_wdata/mem_rdata/mem_ready   memory data and completion
//   busy/done/error/bytes_done      status
module tpu_dma_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [31:0]           cmd_size,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           bytes_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           rd_rem_q, rd_rem_d;
  logic [31:0]           bytes_done_q, bytes_done_d;
  logic                  error_q, error_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];

  logic fifo_full;
  logic bad_cmd;

  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign bad_cmd   = (cmd_size == 32'd0) || (cmd_size[1:0] != 2'b00) ||
                     (cmd_src[1:0] != 2'b00) || (cmd_dst[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    rd_rem_d     = rd_rem_q;
    bytes_done_d = bytes_done_q;
    error_d      = error_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fifo_mem_d   = fifo_mem_q;
    cmd_ready    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rd_addr_d    = cmd_src;
          wr_addr_d    = cmd_dst;
          rd_rem_d     = cmd_size;
          bytes_done_d = 32'd0;
          error_d      = bad_cmd;
          state_d      = bad_cmd ? S_ERR : S_READ;
        end
      end

      S_READ: begin
        mem_addr = rd_addr_q;
        mem_read = !fifo_full;
        if (abort) begin
          state_d  = S_IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else if (mem_ready && !fifo_full) begin
          fifo_mem_d[wr_ptr_q] = mem_rdata;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          count_d   = count_q + 1'b1;
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(4);
          rd_rem_d  = rd_rem_q - 32'd4;
          // This read either fills the FIFO or is the last word of the copy.
          if ((count_q == CNT_W'(FIFO_DEPTH - 1)) || (rd_rem_q == 32'd4)) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = wr_addr_q;
        mem_wdata = fifo_mem_q[rd_ptr_q];
        if (abort) begin
          state_d  = S_IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else if (mem_ready) begin
          rd_ptr_d     = rd_ptr_q + 1'b1;
          count_d      = count_q - 1'b1;
          wr_addr_d    = wr_addr_q + ADDR_WIDTH'(4);
          bytes_done_d = bytes_done_q + 32'd4;
          if (count_q == CNT_W'(1)) begin
            state_d = (rd_rem_q != 32'd0) ? S_READ : S_DONE;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      S_ERR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      rd_rem_q     <= '0;
      bytes_done_q <= '0;
      error_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      rd_rem_q     <= rd_rem_d;
      bytes_done_q <= bytes_done_d;
      error_q      <= error_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset. The pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign busy       = (state_q == S_READ) || (state_q == S_WRITE) || (state_q == S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  assign bytes_done = bytes_done_q;

endmodule

// File: tb/tb_tpu_dma_engine.sv
// tb_tpu_dma_engine: directed bench for tpu_dma_engine.
// The memory returns rdata = addr ^ 32'h5A5A_0000. A transaction-level model
// turns every accepted command into the expected read and write sequences and
// status values. A monitor then compares the DUT against that model on every
// cycle.
module tb_tpu_dma_engine;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_src;
  logic [31:0] cmd_dst;
  logic [31:0] cmd_size;
  logic        abort;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] bytes_done;

  tpu_dma_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_size   (cmd_size),
    .abort      (abort),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bytes_done (bytes_done)
  );

  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- shared bench state ----------------
  int n_checks;
  int n_errors;
  int cyc;
  int acc_cyc;
  int done_cnt;
  int access_cnt;
  int stall_seen;
  int stall_left;
  int wr_seen;
  int cur_run;
  logic stall_en;
  logic pending_done;
  logic err_cycle;
  logic exp_err;
  logic [31:0] exp_bytes;
  logic prev_stall;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;

  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];
  logic [31:0] rd_log_q[$];
  logic [31:0] wa_log_q[$];
  logic [31:0] wd_log_q[$];
  int          run_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model + monitor ----------------
  task automatic monitor_loop();
    logic        active;
    logic [31:0] a;
    logic [31:0] d;
    logic        good;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      mem_ready = 1'b1;
      if (abort) begin
        mem_ready = 1'b0;
      end else if (stall_en && mem_write && wr_seen == 1 && stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
        stall_seen++;
      end

      if (!rst_n) begin
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
        pending_done = 1'b0;
        err_cycle    = 1'b0;
        exp_err      = 1'b0;
        exp_bytes    = 32'd0;
        prev_stall   = 1'b0;
      end else begin
        active = (exp_wa_q.size() != 0) || pending_done;
        chk("done", {31'd0, done}, {31'd0, pending_done});
        chk("busy", {31'd0, busy}, {31'd0, active});
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, !(active || err_cycle)});
        chk("error", {31'd0, error}, {31'd0, exp_err});
        chk("bytes_done", bytes_done, exp_bytes);
        chk("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
        if (mem_read || mem_write) chk("access_while_busy", {31'd0, busy}, 32'd1);
        if (prev_stall) begin
          chk("stall_strobe", {31'd0, mem_write}, 32'd1);
          chk("stall_addr", mem_addr, prev_addr);
          chk("stall_wdata", mem_wdata, prev_wdata);
        end
        prev_stall = mem_write && !mem_ready && !abort;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        if (done) done_cnt++;

        pending_done = 1'b0;
        err_cycle    = 1'b0;

        if (mem_read && mem_ready) begin
          access_cnt++;
          chk("read_expected", {31'd0, exp_rd_q.size() != 0}, 32'd1);
          if (exp_rd_q.size() != 0) begin
            a = exp_rd_q.pop_front();
            chk("rd_addr", mem_addr, a);
          end
          rd_log_q.push_back(mem_addr);
          if (cur_run >= 0) cur_run++;
          else begin
            run_q.push_back(cur_run);
            cur_run = 1;
          end
        end

        if (mem_write && mem_ready) begin
          access_cnt++;
          wr_seen++;
          chk("write_expected", {31'd0, exp_wa_q.size() != 0}, 32'd1);
          if (exp_wa_q.size() != 0) begin
            a = exp_wa_q.pop_front();
            d = exp_wd_q.pop_front();
            chk("wr_addr", mem_addr, a);
            chk("wr_data", mem_wdata, d);
            exp_bytes = exp_bytes + 32'd4;
          end
          wa_log_q.push_back(mem_addr);
          wd_log_q.push_back(mem_wdata);
          if (cur_run <= 0) cur_run--;
          else begin
            run_q.push_back(cur_run);
            cur_run = -1;
          end
          if (exp_wa_q.size() == 0) begin
            pending_done = 1'b1;
            run_q.push_back(cur_run);
          end
        end

        if (abort && exp_wa_q.size() != 0) begin
          exp_rd_q.delete();
          exp_wa_q.delete();
          exp_wd_q.delete();
        end

        if (cmd_valid && cmd_ready) begin
          good = (cmd_size != 0) && (cmd_size[1:0] == 2'b00) &&
                 (cmd_src[1:0] == 2'b00) && (cmd_dst[1:0] == 2'b00);
          exp_err   = !good;
          err_cycle = !good;
          exp_bytes = 32'd0;
          rd_log_q.delete();
          wa_log_q.delete();
          wd_log_q.delete();
          run_q.delete();
          cur_run    = 0;
          wr_seen    = 0;
          stall_left = 3;
          if (good) begin
            for (int i = 0; i < int'(cmd_size >> 2); i++) begin
              a = cmd_src + 32'(4 * i);
              exp_rd_q.push_back(a);
              exp_wa_q.push_back(cmd_dst + 32'(4 * i));
              exp_wd_q.push_back(a ^ 32'h5A5A_0000);
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic [31:0] s, input logic [31:0] d,
                      input logic [31:0] sz, output int waited);
    cmd_src   = s;
    cmd_dst   = d;
    cmd_size  = sz;
    cmd_valid = 1'b1;
    waited    = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_timeout", {31'd0, waited < 50}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int lat);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 200);
    chk("idle_timeout", {31'd0, k < 200}, 32'd1);
    lat = cyc - acc_cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int lat;
    int d0;
    int a0;
    int k;
    int exp_runs[6];
    exp_runs = '{4, -4, 4, -4, 2, -2};
    n_checks = 0; n_errors = 0; cyc = 0; acc_cyc = 0;
    done_cnt = 0; access_cnt = 0; stall_seen = 0; stall_left = 0;
    wr_seen = 0; cur_run = 0; stall_en = 1'b0;
    pending_done = 1'b0; err_cycle = 1'b0; exp_err = 1'b0;
    exp_bytes = 32'd0; prev_stall = 1'b0; prev_addr = 32'd0; prev_wdata = 32'd0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_src = 32'd0; cmd_dst = 32'd0;
    cmd_size = 32'd0; abort = 1'b0; mem_ready = 1'b1;
    fork
      monitor_loop();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_bytes_done", bytes_done, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-word copy
    d0 = done_cnt;
    send(32'h100, 32'h200, 32'd8, w);
    wait_idle(lat);
    chk("copy_latency", 32'(lat), 32'd6);
    chk("copy_bytes", bytes_done, 32'd8);
    chk("copy_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("copy_rd0", rd_log_q[0], 32'h100);
    chk("copy_rd1", rd_log_q[1], 32'h104);
    chk("copy_wa0", wa_log_q[0], 32'h200);
    chk("copy_wd0", wd_log_q[0], 32'h5A5A_0100);
    chk("copy_wa1", wa_log_q[1], 32'h204);
    chk("copy_wd1", wd_log_q[1], 32'h5A5A_0104);

    // Ten words through a four-deep FIFO
    d0 = done_cnt;
    send(32'h1000, 32'h2000, 32'd40, w);
    wait_idle(lat);
    chk("multi_bytes", bytes_done, 32'd40);
    chk("multi_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("multi_phase_count", 32'(run_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("multi_phase_len", 32'(run_q[i]), 32'(exp_runs[i]));

    // Three-cycle stall on the second write
    stall_en = 1'b1;
    stall_seen = 0;
    send(32'h300, 32'h400, 32'd16, w);
    wait_idle(lat);
    stall_en = 1'b0;
    chk("stall_cycles", 32'(stall_seen), 32'd3);
    chk("stall_bytes", bytes_done, 32'd16);
    chk("stall_writes", 32'(wa_log_q.size()), 32'd4);

    // Misaligned size, then a good command clears error
    d0 = done_cnt;
    a0 = access_cnt;
    send(32'h100, 32'h200, 32'd6, w);
    wait_idle(lat);
    chk("bad_error", {31'd0, error}, 32'd1);
    chk("bad_no_done", 32'(done_cnt - d0), 32'd0);
    chk("bad_no_access", 32'(access_cnt - a0), 32'd0);
    send(32'h500, 32'h600, 32'd4, w);
    chk("bad_cleared", {31'd0, error}, 32'd0);
    wait_idle(lat);
    chk("after_bad_bytes", bytes_done, 32'd4);

    // Abort during the first write
    d0 = done_cnt;
    send(32'h700, 32'h800, 32'd16, w);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_write && k < 100);
    chk("abort_reach_write", {31'd0, k < 100}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #2;
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bytes", bytes_done, 32'd0);
    chk("abort_fifo_empty", 32'(dut.count_q), 32'd0);
    @(negedge clk);
    send(32'h900, 32'hA00, 32'd4, w);
    wait_idle(lat);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd1);
    chk("post_abort_bytes", bytes_done, 32'd4);
    chk("post_abort_wd", wd_log_q[0], 32'h5A5A_0900);

    // Source address wraps
    send(32'hFFFF_FFFC, 32'h40, 32'd8, w);
    wait_idle(lat);
    chk("wrap_rd0", rd_log_q[0], 32'hFFFF_FFFC);
    chk("wrap_rd1", rd_log_q[1], 32'h0000_0000);
    chk("wrap_error", {31'd0, error}, 32'd0);
    chk("wrap_bytes", bytes_done, 32'd8);

    // Reset in the middle of a transfer, then immediate accept
    d0 = done_cnt;
    send(32'hB00, 32'hC00, 32'd16, w);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    send(32'hD00, 32'hE00, 32'd4, w);
    chk("accept_after_reset", 32'(w), 32'd0);
    wait_idle(lat);
    chk("midrst_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("midrst_bytes", bytes_done, 32'd4);

    repeat (2) @(negedge clk);
    chk("model_drained", 32'(exp_wa_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
